// File: rtl/tie_release_seq.sv
// Power-up release sequencer: qualifies the tie-high level through a sync chain,
// then raises NDOM enables one at a time. Optional ack timeout: TIE_RELEASE_SEQ_TIMEOUT_EN.
module tie_release_seq #(
    parameter int STAGES = 3,
    parameter int NDOM   = 4,
    parameter int HOLD   = 8,
    parameter int TMO    = 64
) (
    input  logic            ck,
    input  logic            nrst,
    input  logic            one,
    input  logic [NDOM-1:0] ack,
    output logic [NDOM-1:0] en,
    output logic            done,
    output logic            err
);

    localparam int CMAX = (HOLD > TMO) ? HOLD : TMO;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NDOM > 1) ? $clog2(NDOM) : 1;

    localparam logic [CW-1:0]   HOLD_LD  = CW'(HOLD);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(NDOM - 1);
    localparam logic [IW-1:0]   IDX_ZERO = {IW{1'b0}};
    localparam logic [NDOM-1:0] EN_LSB   = NDOM'(1'b1);
    localparam logic [NDOM-1:0] EN_ZERO  = {NDOM{1'b0}};
`ifdef TIE_RELEASE_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0]   TMO_LD   = CW'(TMO);
`endif

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_HOLD  = 3'd1,
        S_WACK  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [STAGES-1:0] sync_r;
    logic [IW-1:0]     idx_r, idx_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [NDOM-1:0]   en_r, en_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic              q_ok_s;
    logic              ack_cur_s;

    assign q_ok_s    = &sync_r;
    assign ack_cur_s = ack[idx_r];

    // Next-state, counter, index and output decode.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        en_s    = en_r;
        done_s  = done_r;
        err_s   = err_r;
        // Losing the tie level re-sequences from scratch; FAULT ignores it.
        if (!q_ok_s && (state_r == S_HOLD || state_r == S_WACK || state_r == S_DONE)) begin
            state_s = S_SYNC;
            idx_s   = IDX_ZERO;
            cnt_s   = CNT_ZERO;
            en_s    = EN_ZERO;
            done_s  = 1'b0;
        end else begin
            case (state_r)
                S_SYNC: begin
                    if (q_ok_s) begin
                        cnt_s   = HOLD_LD;
                        state_s = S_HOLD;
                    end else begin
                        state_s = S_SYNC;
                    end
                end
                S_HOLD: begin
                    if (cnt_r == CNT_ONE) begin
                        en_s    = en_r | (EN_LSB << idx_r);
`ifdef TIE_RELEASE_SEQ_TIMEOUT_EN
                        cnt_s   = TMO_LD;
`else
                        cnt_s   = CNT_ZERO;
`endif
                        state_s = S_WACK;
                    end else if (cnt_r != CNT_ZERO) begin
                        cnt_s = cnt_r - CNT_ONE;
                    end else begin
                        cnt_s = CNT_ZERO;
                    end
                end
                S_WACK: begin
                    if (ack_cur_s) begin
                        if (idx_r == IDX_LAST) begin
                            done_s  = 1'b1;
                            state_s = S_DONE;
                        end else begin
                            idx_s   = idx_r + IDX_ONE;
                            cnt_s   = HOLD_LD;
                            state_s = S_HOLD;
                        end
                    end
`ifdef TIE_RELEASE_SEQ_TIMEOUT_EN
                    // An ack on the expiring edge still wins over the fault.
                    else if (cnt_r <= CNT_ONE) begin
                        state_s = S_FAULT;
                        cnt_s   = CNT_ZERO;
                        en_s    = EN_ZERO;
                        done_s  = 1'b0;
                        err_s   = 1'b1;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
`else
                    else begin
                        state_s = S_WACK;
                    end
`endif
                end
                S_DONE: begin
                    state_s = S_DONE;
                end
                S_FAULT: begin
                    en_s   = EN_ZERO;
                    done_s = 1'b0;
                    err_s  = 1'b1;
                end
                default: begin
                    state_s = S_SYNC;
                    idx_s   = IDX_ZERO;
                    cnt_s   = CNT_ZERO;
                    en_s    = EN_ZERO;
                    done_s  = 1'b0;
                    err_s   = 1'b0;
                end
            endcase
        end
    end

    // State, sync chain and registered outputs with synchronous reset.
    always_ff @(posedge ck) begin
        if (!nrst) begin
            sync_r  <= {STAGES{1'b0}};
            state_r <= S_SYNC;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
            en_r    <= EN_ZERO;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            sync_r  <= {sync_r[STAGES-2:0], one};
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            en_r    <= en_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign en   = en_r;
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: tb/tb_tie_release_seq.sv
// Scoreboard bench for tie_release_seq: every output change is matched against
// a queue of hand-computed {edge, en, done, err} events.
module tb_tie_release_seq;

    localparam int NDOM = 4;

    logic            ck = 1'b0;
    logic            nrst;
    logic            one;
    logic [NDOM-1:0] ack;
    logic [NDOM-1:0] en;
    logic            done;
    logic            err;

    logic [NDOM-1:0] loop_mask;
    logic [NDOM-1:0] ack_force;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int              edge_n;
        logic [NDOM-1:0] en;
        logic            done;
        logic            err;
    } exp_t;

    exp_t sb[$];

    tie_release_seq #(.STAGES(3), .NDOM(NDOM), .HOLD(8), .TMO(64)) dut (
        .ck   (ck),
        .nrst (nrst),
        .one  (one),
        .ack  (ack),
        .en   (en),
        .done (done),
        .err  (err)
    );

    assign ack = (en & loop_mask) | ack_force;

    always #5 ck = ~ck;

    always @(posedge ck) cyc++;

    // Monitor: any change of the outputs must match the head of the scoreboard.
    logic [NDOM+1:0] prev_m;
    logic            first_m = 1'b1;
    int              nev_m   = 0;
    always @(negedge ck) begin
        logic [NDOM+1:0] cur;
        exp_t            e;
        cur = {en, done, err};
        if (first_m || cur !== prev_m) begin
            checks++;
            nev_m++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change #%0d: edge %0d got en=%b done=%b err=%b, required no change",
                         nev_m, cyc, en, done, err);
            end else begin
                e = sb.pop_front();
                if (cur !== {e.en, e.done, e.err} || cyc != e.edge_n) begin
                    errors++;
                    $display("FAIL out_event #%0d: got edge %0d en=%b done=%b err=%b, required edge %0d en=%b done=%b err=%b",
                             nev_m, cyc, en, done, err, e.edge_n, e.en, e.done, e.err);
                end
            end
            prev_m  = cur;
            first_m = 1'b0;
        end
    end

    task automatic push(input int edge_n, input logic [NDOM-1:0] e, input logic d, input logic r);
        exp_t x;
        x.edge_n = edge_n;
        x.en     = e;
        x.done   = d;
        x.err    = r;
        sb.push_back(x);
    endtask

    // Full loop-back sequence anchored at t0 (edge t0+1 is the first edge out of reset).
    task automatic push_seq(input int t0);
        push(t0 + 12, 4'b0001, 1'b0, 1'b0);
        push(t0 + 21, 4'b0011, 1'b0, 1'b0);
        push(t0 + 30, 4'b0111, 1'b0, 1'b0);
        push(t0 + 39, 4'b1111, 1'b0, 1'b0);
        push(t0 + 40, 4'b1111, 1'b1, 1'b0);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge ck);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge ck);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d events pending after %0d cycles, required 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    initial begin
        int t0;
        int c;
        nrst      = 1'b0;
        one       = 1'b1;
        loop_mask = 4'b1111;
        ack_force = 4'b0000;
        push(1, 4'b0000, 1'b0, 1'b0);

        // Plain loop-back bring-up.
        repeat (3) @(negedge ck);
        nrst = 1'b1;
        t0 = cyc;
        push_seq(t0);
        drain(60);

        // Reset from DONE, then reset again mid-sequence at en=0011.
        @(negedge ck);
        nrst = 1'b0;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0);
        @(negedge ck);
        @(negedge ck);
        nrst = 1'b1;
        t0 = cyc;
        push(t0 + 12, 4'b0001, 1'b0, 1'b0);
        push(t0 + 21, 4'b0011, 1'b0, 1'b0);
        wait_to(t0 + 25);
        nrst = 1'b0;
        push(t0 + 26, 4'b0000, 1'b0, 1'b0);
        @(negedge ck);
        @(negedge ck);
        nrst = 1'b1;
        t0 = cyc;
        push_seq(t0);
        drain(60);

        // One-cycle glitch on the tie level while in DONE.
        @(negedge ck);
        one = 1'b0;
        c = cyc;
        push(c + 2, 4'b0000, 1'b0, 1'b0);
        @(negedge ck);
        one = 1'b1;
        push_seq(c + 1);
        drain(60);

`ifndef TIE_RELEASE_SEQ_TIMEOUT_EN
        // ack[2] early, ack[1] withheld for 100 cycles.
        @(negedge ck);
        nrst      = 1'b0;
        loop_mask = 4'b1101;
        ack_force = 4'b0100;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0);
        @(negedge ck);
        @(negedge ck);
        nrst = 1'b1;
        t0 = cyc;
        push(t0 + 12,  4'b0001, 1'b0, 1'b0);
        push(t0 + 21,  4'b0011, 1'b0, 1'b0);
        push(t0 + 130, 4'b0111, 1'b0, 1'b0);
        push(t0 + 139, 4'b1111, 1'b0, 1'b0);
        push(t0 + 140, 4'b1111, 1'b1, 1'b0);
        wait_to(t0 + 121);
        ack_force = 4'b0110;
        drain(60);
`else
        // ack[0] never returns: fault 64 edges after en[0]; sticky through a tie glitch.
        @(negedge ck);
        nrst      = 1'b0;
        loop_mask = 4'b1110;
        ack_force = 4'b0000;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0);
        @(negedge ck);
        @(negedge ck);
        nrst = 1'b1;
        t0 = cyc;
        push(t0 + 12, 4'b0001, 1'b0, 1'b0);
        push(t0 + 76, 4'b0000, 1'b0, 1'b1);
        wait_to(t0 + 90);
        one = 1'b0;
        @(negedge ck);
        one = 1'b1;
        wait_to(t0 + 110);
        nrst = 1'b0;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0);
        @(negedge ck);
        @(negedge ck);
        drain(10);

        // ack[0] arrives on the very edge the timeout expires.
        nrst = 1'b1;
        t0 = cyc;
        push(t0 + 12,  4'b0001, 1'b0, 1'b0);
        push(t0 + 84,  4'b0011, 1'b0, 1'b0);
        push(t0 + 93,  4'b0111, 1'b0, 1'b0);
        push(t0 + 102, 4'b1111, 1'b0, 1'b0);
        push(t0 + 103, 4'b1111, 1'b1, 1'b0);
        wait_to(t0 + 75);
        ack_force = 4'b0001;
        drain(60);
`endif

        repeat (10) @(negedge ck);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
